// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and helpers for the FIR averaging output stage
// Contents:
//   W_DEF        default sample width
//   WARM         accepted input beats discarded after reset
//   fifo_lvl_w   width of a FIFO occupancy count for a given depth
//   avg4_round   rounded 4-sample average of a window sum
package fir_pkg;

  localparam int W_DEF = 16;
  localparam int WARM  = 4;

  // Occupancy needs one bit beyond the pointer index so that "full" (== depth)
  // is distinguishable from "empty".
  function automatic int fifo_lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Round-half-up divide by 4. Evaluated wide so the +2 can never wrap; the
  // caller truncates to its sample width. The largest legal sum
  // 2^(w+2)-4 maps exactly onto 2^w-1, so truncation never loses a set bit.
  function automatic logic [63:0] avg4_round(input logic [63:0] s);
    return (s + 64'd2) >> 2;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// rtl/fir_sync_fifo.sv - single-clock FIFO holding the kept averages
// Ports:
//   i_clk, i_reset   clock, synchronous active-low reset (clears storage too)
//   i_push, i_din    write request and data; ignored when full unless popping
//   i_pop            read request; ignored when empty
//   o_dout           head entry (combinational read of storage)
//   o_full, o_empty  occupancy flags
//   o_level          occupancy, 0..DEPTH
module fir_sync_fifo
  import fir_pkg::*;
#(
  parameter int w     = W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_push,
  input  logic [w-1:0]                  i_din,
  input  logic                          i_pop,
  output logic [w-1:0]                  o_dout,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [fifo_lvl_w(DEPTH)-1:0]  o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = fifo_lvl_w(DEPTH);

  logic [w-1:0]  r_mem [DEPTH];
  logic [LW-1:0] r_wr_ptr;
  logic [LW-1:0] r_rd_ptr;
  logic          w_do_push;
  logic          w_do_pop;

  // Pointers carry an extra MSB; their difference is the occupancy directly.
  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_empty = (o_level == '0);
  assign o_full  = (o_level == LW'(DEPTH));

  // A push into a full FIFO still succeeds when the head leaves the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_dout = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        r_wr_ptr                <= r_wr_ptr + LW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + LW'(1);
      end
    end
  end

endmodule

// File: rtl/fir_avg_out.sv
// rtl/fir_avg_out.sv - warm-up discard, rounding, decimation and output FIFO after the FIR sum
// Ports:
//   i_clk, i_reset   clock, synchronous active-low reset
//   i_in_valid       i_s carries a new window sum this cycle
//   i_s              unsigned (w+2)-bit window sum
//   i_dec            decimation control, factor = i_dec+1
//   o_out_data       head-of-FIFO average
//   o_out_valid      FIFO non-empty
//   i_out_ready      consumer takes o_out_data this cycle
//   o_level          FIFO occupancy
//   o_overflow       sticky: a kept sample was dropped on a full FIFO
module fir_avg_out
  import fir_pkg::*;
#(
  parameter int w     = fir_pkg::W_DEF,
  parameter int DEPTH = 4,
  parameter int DEC_W = 4,
  parameter int WARM  = fir_pkg::WARM
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_in_valid,
  input  logic [w+1:0]                  i_s,
  input  logic [DEC_W-1:0]              i_dec,
  output logic [w-1:0]                  o_out_data,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [fifo_lvl_w(DEPTH)-1:0]  o_level,
  output logic                          o_overflow
);

  localparam int WARM_W = (WARM > 0) ? $clog2(WARM + 1) : 1;

  logic [WARM_W-1:0] r_warm;
  logic [DEC_W-1:0]  r_phase;
  logic [DEC_W-1:0]  r_dec_q;
  logic              r_overflow;

  logic              w_warm_done;
  logic              w_post;
  logic              w_keep;
  logic [DEC_W-1:0]  w_dec_eff;
  logic [w-1:0]      w_avg;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;

  assign w_warm_done = (r_warm == WARM_W'(WARM));
  assign w_post      = i_in_valid && w_warm_done;
  assign w_keep      = w_post && (r_phase == '0);

  // On a kept beat the freshly sampled factor governs the wrap, otherwise a
  // kept beat with phase 0 would compare against the previous factor.
  assign w_dec_eff = w_keep ? i_dec : r_dec_q;

  assign w_avg = w'(avg4_round(64'(i_s)));

  assign o_out_valid = !w_empty;
  assign w_pop       = o_out_valid && i_out_ready;
  assign o_overflow  = r_overflow;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_warm     <= '0;
      r_phase    <= '0;
      r_dec_q    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (i_in_valid && !w_warm_done) begin
        r_warm <= r_warm + WARM_W'(1);
      end
      if (w_post) begin
        r_phase <= (r_phase == w_dec_eff) ? '0 : r_phase + DEC_W'(1);
      end
      if (w_keep) begin
        r_dec_q <= i_dec;
      end
      // Dropped push: the FIFO rejects it internally, only the flag records it.
      if (w_keep && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  fir_sync_fifo #(
    .w     (w),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_keep),
    .i_din   (w_avg),
    .i_pop   (w_pop),
    .o_dout  (o_out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_level)
  );

endmodule

// File: tb/tb_fir_avg_out.sv
// tb/tb_fir_avg_out.sv - self-checking bench for fir_avg_out
module tb_fir_avg_out;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int DEC_W = 4;
  localparam int WARM  = 4;

  logic           clk = 1'b0;
  logic           i_reset = 1'b0;
  logic           i_in_valid = 1'b0;
  logic [W+1:0]   i_s = '0;
  logic [DEC_W-1:0] i_dec = '0;
  logic [W-1:0]   o_out_data;
  logic           o_out_valid;
  logic           i_out_ready = 1'b0;
  logic [2:0]     o_level;
  logic           o_overflow;

  always #5 clk = ~clk;

  fir_avg_out #(
    .w     (W),
    .DEPTH (DEPTH),
    .DEC_W (DEC_W),
    .WARM  (WARM)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_in_valid  (i_in_valid),
    .i_s         (i_s),
    .i_dec       (i_dec),
    .o_out_data  (o_out_data),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_level     (o_level),
    .o_overflow  (o_overflow)
  );

  int total = 0;
  int bad   = 0;

  // Model state: expected FIFO contents, sticky flag, beat bookkeeping.
  int mq[$];
  int got[$];
  bit m_ov;
  int m_acc;
  int m_k;
  int m_next;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic compare();
    chk("out_valid", o_out_valid, 64'(mq.size() != 0));
    chk("level", o_level, 64'(mq.size()));
    chk("overflow", o_overflow, 64'(m_ov));
    if (mq.size() > 0) chk("out_data", o_out_data, 64'(mq[0]));
  endtask

  task automatic model_clear();
    mq.delete();
    m_ov   = 1'b0;
    m_acc  = 0;
    m_k    = 0;
    m_next = 0;
  endtask

  task automatic do_reset();
    i_reset    = 1'b0;
    i_in_valid = 1'b0;
    @(posedge clk);
    #1;
    i_reset = 1'b1;
    model_clear();
    compare();
  endtask

  // One clock: drive inputs, advance the model, then check after the edge.
  task automatic cyc(input bit v, input int sv, input int dv, input bit rdy);
    bit pop;
    bit keep;
    bit full;
    logic [31:0] sv_l;
    logic [31:0] dv_l;
    sv_l        = sv;
    dv_l        = dv;
    i_in_valid  = v;
    i_s         = sv_l[W+1:0];
    i_dec       = dv_l[DEC_W-1:0];
    i_out_ready = rdy;
    full = (mq.size() == DEPTH);
    pop  = (mq.size() > 0) && rdy;
    if (pop) got.push_back(int'(o_out_data));
    keep = 1'b0;
    if (v) begin
      if (m_acc < WARM) m_acc++;
      else begin
        // Kept beats are spaced dec+1 post-warm-up beats apart.
        if (m_k == m_next) begin
          keep   = 1'b1;
          m_next = m_k + dv + 1;
        end
        m_k++;
      end
    end
    if (pop) void'(mq.pop_front());
    if (keep) begin
      if (full && !pop) m_ov = 1'b1;
      else mq.push_back((sv + 2) / 4);
    end
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic chk_got(input string name, input int n, input int e0, input int e1,
                         input int e2, input int e3, input int e4);
    int ev[5];
    ev = '{e0, e1, e2, e3, e4};
    chk({name, "_count"}, 64'(got.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      chk(name, (i < got.size()) ? 64'(got[i]) : 64'hFFFF_FFFF, 64'(ev[i]));
    end
  endtask

  initial begin
    model_clear();

    // Reset state
    do_reset();
    chk("rst_out_data", o_out_data, 64'd0);
    chk("rst_valid", o_out_valid, 64'd0);

    // Basic flow
    got.delete();
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, 100, 0, 1'b1);
      if (i == 4) chk("bf_no_out_beat4", o_out_valid, 64'd0);
      if (i == 5) begin
        chk("bf_first_valid", o_out_valid, 64'd1);
        chk("bf_first_data", o_out_data, 64'd25);
      end
    end
    chk("bf_popped0", (got.size() > 0) ? 64'(got[0]) : 64'd0, 64'd25);

    // Rounding
    cyc(1'b0, 0, 0, 1'b1);
    cyc(1'b0, 0, 0, 1'b1);
    got.delete();
    cyc(1'b1, 5, 0, 1'b1);
    cyc(1'b1, 6, 0, 1'b1);
    cyc(1'b1, 2, 0, 1'b1);
    cyc(1'b1, 262140, 0, 1'b1);
    cyc(1'b0, 0, 0, 1'b1);
    cyc(1'b0, 0, 0, 1'b1);
    chk_got("round", 4, 1, 2, 1, 65535, 0);

    // Decimation with gaps, then a factor change taking effect after a kept beat
    do_reset();
    got.delete();
    for (int i = 0; i < WARM; i++) begin
      cyc(1'b1, 0, 2, 1'b1);
      cyc(1'b0, 0, 2, 1'b1);
    end
    for (int k = 1; k <= 11; k++) begin
      cyc(1'b1, 4 * k, (k >= 10) ? 0 : 2, 1'b1);
      cyc(1'b0, 0, (k >= 10) ? 0 : 2, 1'b1);
    end
    chk_got("decim", 5, 1, 4, 7, 10, 11);

    // Overflow under back-pressure
    do_reset();
    for (int i = 0; i < WARM; i++) cyc(1'b1, 0, 0, 1'b0);
    for (int k = 1; k <= 5; k++) cyc(1'b1, 40 * k, 0, 1'b0);
    chk("ovf_level", o_level, 64'd4);
    chk("ovf_flag", o_overflow, 64'd1);
    got.delete();
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 0, 1'b1);
    chk_got("ovf_drain", 4, 10, 20, 30, 40, 0);
    chk("ovf_empty", o_out_valid, 64'd0);

    // Full with simultaneous push and pop
    got.delete();
    for (int k = 11; k <= 14; k++) cyc(1'b1, 4 * k, 0, 1'b0);
    cyc(1'b1, 60, 0, 1'b1);
    chk("fullpp_level", o_level, 64'd4);
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 0, 1'b1);
    chk_got("fullpp_drain", 5, 11, 12, 13, 14, 15);

    // Reset mid-stream
    for (int k = 21; k <= 25; k++) cyc(1'b1, 4 * k, 0, 1'b0);
    chk("mid_full_level", o_level, 64'd4);
    chk("mid_full_ovf", o_overflow, 64'd1);
    do_reset();
    chk("mid_rst_valid", o_out_valid, 64'd0);
    chk("mid_rst_level", o_level, 64'd0);
    chk("mid_rst_ovf", o_overflow, 64'd0);
    for (int i = 0; i < WARM; i++) begin
      cyc(1'b1, 400, 0, 1'b1);
      chk("mid_warm_level", o_level, 64'd0);
    end
    cyc(1'b1, 400, 0, 1'b1);
    chk("mid_after_valid", o_out_valid, 64'd1);
    chk("mid_after_data", o_out_data, 64'd100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
